// File: rtl/bcd_updown_counter.sv
// Cascaded BCD up/down counter with parallel load, carry/borrow out and
// rejected-load flag. WRAP selects wrap-around (1) or saturation (0) at terminal counts.
module bcd_updown_counter #(
  parameter int DIGITS = 4,
  parameter int WRAP   = 1
) (
  input  logic                  CLK,
  input  logic                  Clear_b,
  input  logic [4*DIGITS-1:0]   Data_in,
  input  logic                  Load,
  input  logic                  Count,
  input  logic                  Up,
  output logic [4*DIGITS-1:0]   A_count,
  output logic                  C_out,
  output logic                  B_out,
  output logic                  Load_err
);

  logic [4*DIGITS-1:0] a_count_q, a_count_d;
  logic                load_err_q, load_err_d;

  logic [4*DIGITS-1:0] inc_val;
  logic [4*DIGITS-1:0] dec_val;
  logic [DIGITS-1:0]   digit_is9;
  logic [DIGITS-1:0]   digit_is0;
  logic [DIGITS-1:0]   din_bad;
  // low9[k]/low0[k]: every digit below k is 9 / 0, i.e. digit k sees a carry / borrow
  logic [DIGITS:0]     low9;
  logic [DIGITS:0]     low0;
  logic                any_bad;
  logic                all9;
  logic                all0;

  assign low9[0] = 1'b1;
  assign low0[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi = gi + 1) begin : g_digit
      logic [3:0] cur;
      assign cur           = a_count_q[4*gi +: 4];
      assign digit_is9[gi] = (cur == 4'd9);
      assign digit_is0[gi] = (cur == 4'd0);
      assign din_bad[gi]   = (Data_in[4*gi +: 4] > 4'd9);
      assign low9[gi+1]    = low9[gi] & digit_is9[gi];
      assign low0[gi+1]    = low0[gi] & digit_is0[gi];
      assign inc_val[4*gi +: 4] = !low9[gi]      ? cur :
                                  digit_is9[gi]  ? 4'd0 : cur + 4'd1;
      assign dec_val[4*gi +: 4] = !low0[gi]      ? cur :
                                  digit_is0[gi]  ? 4'd9 : cur - 4'd1;
    end
  endgenerate

  assign any_bad = |din_bad;
  assign all9    = low9[DIGITS];
  assign all0    = low0[DIGITS];

  always_comb begin
    a_count_d  = a_count_q;
    load_err_d = 1'b0;
    if (Load) begin
      if (any_bad) begin
        load_err_d = 1'b1;
      end else begin
        a_count_d = Data_in;
      end
    end else if (Count) begin
      // Incrementing all-9s naturally rolls to all-0s (and vice versa), so only saturation needs a guard
      if (Up) begin
        if (!(all9 && (WRAP == 0))) begin
          a_count_d = inc_val;
        end
      end else begin
        if (!(all0 && (WRAP == 0))) begin
          a_count_d = dec_val;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge Clear_b) begin
    if (!Clear_b) begin
      a_count_q  <= '0;
      load_err_q <= 1'b0;
    end else begin
      a_count_q  <= a_count_d;
      load_err_q <= load_err_d;
    end
  end

  assign A_count  = a_count_q;
  assign Load_err = load_err_q;
  assign C_out    = Count & ~Load & Up  & all9;
  assign B_out    = Count & ~Load & ~Up & all0;

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter DIGITS, default 4: number of cascaded BCD digits; the legal range is 1..8.
REQ-002 Parameter WRAP, default 1: 1 means wrap-around at terminal values, 0 means saturate at terminal values.
REQ-003 Port CLK, input, 1 bit: single clock, positive-edge sensitive.
REQ-004 Port Clear_b, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port Data_in, input, 4*DIGITS bits: parallel load value; digit k occupies bits [4k+3:4k], and digit 0 is the least significant.
REQ-006 Port Load, input, 1 bit: active high; requests a parallel load.
REQ-007 Port Count, input, 1 bit: active high; count enable.
REQ-008 Port Up, input, 1 bit: count direction; 1 means increment, 0 means decrement.
REQ-009 Port A_count, output, 4*DIGITS bits: registered BCD count, using the same digit packing as Data_in.
REQ-010 Port C_out, output, 1 bit: combinational carry-out (terminal count while counting up).
REQ-011 Port B_out, output, 1 bit: combinational borrow-out (terminal count while counting down).
REQ-012 Port Load_err, output, 1 bit: registered one-cycle pulse flagging a rejected load.

Function
REQ-013 Per-edge priority SHALL be: Clear_b low, then Load, then Count, then hold.
REQ-014 When Load=1 and every digit of Data_in is 0..9, A_count SHALL take Data_in on the next edge, with 1-cycle latency.
REQ-015 When Load=1 and any digit of Data_in is 0xA..0xF, A_count SHALL hold and Load_err SHALL be 1 for exactly the following cycle.
REQ-016 Load_err SHALL be 0 in every cycle not covered by REQ-015.
REQ-017 Count=1, Load=0, Up=1: A_count SHALL increment by one in decimal.
- Digit 0 increments every enabled cycle.
- Digit k increments only when digits 0..k-1 are all 9.
- A digit at 9 that increments becomes 0.
REQ-018 Count=1, Load=0, Up=0: A_count SHALL decrement by one in decimal.
- Digit k decrements only when digits 0..k-1 are all 0.
- A digit at 0 that decrements becomes 9.
REQ-019 WRAP=1: all-9s counting up SHALL become all-0s, and all-0s counting down SHALL become all-9s.
REQ-020 WRAP=0: all-9s counting up SHALL hold, and all-0s counting down SHALL hold.
REQ-021 C_out SHALL equal Count AND NOT Load AND Up AND (every digit equals 9), independent of WRAP.
REQ-022 B_out SHALL equal Count AND NOT Load AND NOT Up AND (every digit equals 0), independent of WRAP.
REQ-023 When Count=0 and Load=0, A_count SHALL hold.
REQ-024 A change of Up between cycles SHALL take effect on the next edge with no dead cycle.
REQ-025 Behaviour with a non-BCD digit in A_count is unreachable.
- No load path or count path produces a non-BCD digit.
- No recovery logic is required.
REQ-026 Load and Count asserted together SHALL load (or reject) with no count, and C_out and B_out SHALL be 0 that cycle.
REQ-027 A_count digits SHALL never take values outside 0..9 after any operation.

Reset
REQ-028 Clear_b low SHALL immediately, without waiting for a clock edge, force A_count to all-0s and Load_err to 0.
REQ-029 While Clear_b is low, Load and Count SHALL be ignored.
REQ-030 C_out SHALL follow REQ-021 during reset, so it is 0 because A_count is 0.
REQ-031 B_out SHALL follow REQ-022 during reset.
REQ-032 Counting SHALL resume on the first rising edge after Clear_b deasserts.
REQ-033 Reset asserted mid-operation, including during a pending Load_err pulse, SHALL abort that operation with no residual effect.

Verification (DIGITS=4 unless noted)
REQ-034 Ripple carry: load 0x0999, Count=1, Up=1, one edge -> A_count=0x1000 and C_out=0 during that cycle.
REQ-035 Wrap versus saturate: A_count=0x9999, Count=1, Up=1.
- C_out=1 before the edge.
- WRAP=1: 0x0000 after the edge.
- WRAP=0: 0x9999 after the edge, and C_out stays 1.
REQ-036 Down and borrow: A_count=0x0000, Count=1, Up=0.
- B_out=1 before the edge.
- WRAP=1: 0x9999 after the edge.
- WRAP=0: 0x0000 after the edge.
- Next, load 0x1000 and decrement once -> 0x0999.
REQ-037 Bad load: A_count=0x0042, Load=1, Data_in=0x12A4 -> A_count stays 0x0042 and Load_err=1 for exactly one cycle.
REQ-038 Load over count: Load=1, Count=1, Data_in=0x9999 -> 0x9999 after the edge, with C_out=0 that cycle.
REQ-039 Async reset: pull Clear_b low mid-cycle while counting -> A_count=0x0000 before the next edge.
- Release Clear_b, then count up 3 edges -> 0x0003.
- Repeat with DIGITS=1: 9 counting up wraps to 0 with C_out=1.
